// File: rtl/banked_mem_pkg.sv
// Shared types and default sizing for the banked memory controller.
// Command encoding and FSM state live here so bench and RTL agree.
package banked_mem_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ADDR_W    = 6;
  localparam int DEF_NUM_BANKS = 4;

  typedef enum logic [1:0] {
    OP_READ      = 2'b00,
    OP_WRITE     = 2'b01,
    OP_READ_NEXT = 2'b10,
    OP_CLEAR     = 2'b11
  } cmd_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/banked_mem_ctrl_if.sv
// Command / read-response bundle for banked_mem_ctrl.
// The master drives commands; the slave returns read data and status.
interface banked_mem_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int BANK_W = 2
);
  logic              ena;
  logic              cmd_valid;
  logic [1:0]        cmd_op;
  logic [BANK_W-1:0] cmd_bank;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              cmd_drop;

  modport master (
    output ena, cmd_valid, cmd_op, cmd_bank, cmd_addr, wr_data,
    input  rd_data, rd_valid, busy, cmd_drop
  );

  modport slave (
    input  ena, cmd_valid, cmd_op, cmd_bank, cmd_addr, wr_data,
    output rd_data, rd_valid, busy, cmd_drop
  );
endinterface

// File: rtl/banked_mem_ctrl_mem_bank.sv
// Single-port synchronous RAM bank, one-cycle registered read.
// No backpressure; the read register only updates on re so it holds otherwise.
module mem_bank #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/banked_mem_ctrl.sv
// Banked RAM controller: read/write/streaming read and per-bank clear sweep.
// Reads return after one cycle; commands arriving while busy are dropped and flagged.
module banked_mem_ctrl
  import banked_mem_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_BANKS = DEF_NUM_BANKS
) (
  input logic              clk,
  input logic              rst_n,
  banked_mem_ctrl_if.slave bus
);
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam logic [ADDR_W-1:0] LAST_WORD = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic [BANK_W-1:0] clr_bank_q;
  logic [BANK_W-1:0] ptr_bank_q;
  logic [ADDR_W-1:0] ptr_addr_q;
  logic [BANK_W-1:0] rd_sel_q;
  logic              rd_valid_q;
  logic              drop_q;

  cmd_op_e           op;
  logic              busy;
  logic              accept;
  logic              clear_act;
  logic              is_read;
  logic [BANK_W-1:0] acc_bank;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] bank_rdata [NUM_BANKS];

  assign op        = cmd_op_e'(bus.cmd_op);
  assign busy      = (state_q == ST_CLEAR);
  // rst_n gates everything so nothing (memory included) moves in a reset cycle.
  assign accept    = rst_n && bus.ena && bus.cmd_valid && !busy;
  assign clear_act = rst_n && bus.ena && busy;
  assign is_read   = (op == OP_READ) || (op == OP_READ_NEXT);
  assign acc_bank  = (op == OP_READ_NEXT) ? ptr_bank_q : bus.cmd_bank;
  assign acc_addr  = (op == OP_READ_NEXT) ? ptr_addr_q : bus.cmd_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && op == OP_CLEAR) begin
          state_d = ST_CLEAR;
          sweep_d = '0;
        end
      end
      ST_CLEAR: begin
        if (bus.ena) begin
          sweep_d = sweep_q + 1'b1;
          if (sweep_q == LAST_WORD) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_bank_q <= '0;
      ptr_addr_q <= '0;
      clr_bank_q <= '0;
      rd_sel_q   <= '0;
      rd_valid_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      rd_valid_q <= accept && is_read;
      if (accept) begin
        case (op)
          OP_READ, OP_WRITE: begin
            ptr_bank_q <= bus.cmd_bank;
            ptr_addr_q <= bus.cmd_addr + 1'b1;
          end
          OP_READ_NEXT: ptr_addr_q <= ptr_addr_q + 1'b1;
          OP_CLEAR:     clr_bank_q <= bus.cmd_bank;
          default: ;
        endcase
        if (is_read) rd_sel_q <= acc_bank;
      end
      if (bus.ena && bus.cmd_valid && busy) drop_q <= 1'b1;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic sel_clr, sel_wr, sel_rd;
    assign sel_clr = clear_act && (clr_bank_q == BANK_W'(b));
    assign sel_wr  = accept && (op == OP_WRITE) && (acc_bank == BANK_W'(b));
    assign sel_rd  = accept && is_read && (acc_bank == BANK_W'(b));

    mem_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (sel_clr || sel_wr),
      .re    (sel_rd),
      .addr  (sel_clr ? sweep_q : acc_addr),
      .wdata (sel_clr ? {DATA_W{1'b0}} : bus.wr_data),
      .rdata (bank_rdata[b])
    );
  end

  // Only the last-read bank's register is selected, and it only moves on a read.
  assign bus.rd_data  = bank_rdata[rd_sel_q];
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = busy;
  assign bus.cmd_drop = drop_q;
endmodule

// File: tb/tb_banked_mem_ctrl.sv
// Directed self-checking bench for banked_mem_ctrl: table vectors plus sweep/reset/enable sequences.
module tb_banked_mem_ctrl;
  import banked_mem_pkg::*;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  banked_mem_ctrl_if #(.DATA_W(8), .ADDR_W(6), .BANK_W(2)) bus ();

  banked_mem_ctrl #(.DATA_W(8), .ADDR_W(6), .NUM_BANKS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [1:0] bank;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic       exp_vld;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] bank,
                       input logic [5:0] addr, input logic [7:0] data);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_bank  = bank;
    bus.cmd_addr  = addr;
    bus.wr_data   = data;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    vecs[0]  = '{OP_WRITE,     2'd0, 6'd0,  8'h0F, 1'b0, 8'h00};
    vecs[1]  = '{OP_WRITE,     2'd0, 6'd5,  8'h5A, 1'b0, 8'h00};
    vecs[2]  = '{OP_WRITE,     2'd1, 6'd5,  8'hA5, 1'b0, 8'h00};
    vecs[3]  = '{OP_READ,      2'd1, 6'd5,  8'h00, 1'b1, 8'hA5};
    vecs[4]  = '{OP_READ,      2'd0, 6'd5,  8'h00, 1'b1, 8'h5A};
    vecs[5]  = '{OP_WRITE,     2'd2, 6'd62, 8'h11, 1'b0, 8'h5A};
    vecs[6]  = '{OP_WRITE,     2'd2, 6'd63, 8'h22, 1'b0, 8'h5A};
    vecs[7]  = '{OP_WRITE,     2'd2, 6'd0,  8'h33, 1'b0, 8'h5A};
    vecs[8]  = '{OP_WRITE,     2'd2, 6'd1,  8'h44, 1'b0, 8'h5A};
    vecs[9]  = '{OP_READ,      2'd2, 6'd62, 8'h00, 1'b1, 8'h11};
    vecs[10] = '{OP_READ_NEXT, 2'd0, 6'd0,  8'h00, 1'b1, 8'h22};
    vecs[11] = '{OP_READ_NEXT, 2'd0, 6'd0,  8'h00, 1'b1, 8'h33};
    vecs[12] = '{OP_READ_NEXT, 2'd0, 6'd0,  8'h00, 1'b1, 8'h44};
    vecs[13] = '{OP_WRITE,     2'd1, 6'd8,  8'hD4, 1'b0, 8'h44};
    vecs[14] = '{OP_WRITE,     2'd1, 6'd7,  8'hC3, 1'b0, 8'h44};
    vecs[15] = '{OP_READ_NEXT, 2'd3, 6'd33, 8'h00, 1'b1, 8'hD4};

    rst_n         = 1'b0;
    bus.ena       = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_bank  = 2'd0;
    bus.cmd_addr  = 6'd0;
    bus.wr_data   = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("reset_rd_data",  32'(bus.rd_data),  32'h00);
    check("reset_busy",     32'(bus.busy),     32'd0);
    check("reset_cmd_drop", 32'(bus.cmd_drop), 32'd0);
    rst_n = 1'b1;

    // Rows run back-to-back, one command per cycle.
    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].op, vecs[i].bank, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d_rd_valid", i), 32'(bus.rd_valid), 32'(vecs[i].exp_vld));
      check($sformatf("vec%0d_rd_data", i),  32'(bus.rd_data),  32'(vecs[i].exp_data));
    end

    // Command during the reset cycle is ignored; pointer returns to bank0/addr0.
    issue(OP_WRITE, 2'd0, 6'd20, 8'h12);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_WRITE;
    bus.cmd_addr  = 6'd20;
    bus.wr_data   = 8'hEE;
    rst_n         = 1'b0;
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    bus.cmd_valid = 1'b0;
    check("rst2_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst2_rd_data",  32'(bus.rd_data),  32'h00);
    issue(OP_READ_NEXT, 2'd2, 6'd9, 8'h00);
    check("ptr_after_reset", 32'(bus.rd_data), 32'h0F);
    issue(OP_READ, 2'd0, 6'd20, 8'h00);
    check("reset_cmd_ignored", 32'(bus.rd_data), 32'h12);

    // Clear sweep with a dropped command in the first busy cycle.
    for (int i = 0; i < 64; i++) issue(OP_WRITE, 2'd3, 6'(i), 8'(8'h40 + i));
    issue(OP_WRITE, 2'd0, 6'd31, 8'h31);
    issue(OP_WRITE, 2'd0, 6'd30, 8'h30);
    issue(OP_CLEAR, 2'd3, 6'd0, 8'h00);
    check("clear_busy_start", 32'(bus.busy), 32'd1);
    issue(OP_READ, 2'd0, 6'd5, 8'h00);
    n = 1;
    check("drop_no_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("drop_flag_set",    32'(bus.cmd_drop), 32'd1);
    while (bus.busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("clear_busy_cycles", 32'(n), 32'd64);
    issue(OP_READ_NEXT, 2'd1, 6'd0, 8'h00);
    check("ptr_kept_by_clear", 32'(bus.rd_data), 32'h31);
    for (int i = 0; i < 64; i++) begin
      issue(OP_READ, 2'd3, 6'(i), 8'h00);
      check($sformatf("cleared_b3_w%0d", i), 32'(bus.rd_data), 32'h00);
    end
    issue(OP_READ, 2'd0, 6'd5, 8'h00);
    check("bank0_intact", 32'(bus.rd_data), 32'h5A);
    check("drop_sticky",  32'(bus.cmd_drop), 32'd1);

    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("drop_cleared_by_reset", 32'(bus.cmd_drop), 32'd0);

    // Enable stalls the sweep for 5 cycles; commands meanwhile are ignored.
    issue(OP_CLEAR, 2'd2, 6'd0, 8'h00);
    n = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      n++;
    end
    bus.ena       = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_READ;
    bus.cmd_bank  = 2'd0;
    bus.cmd_addr  = 6'd5;
    repeat (5) begin
      @(posedge clk);
      #1;
      n++;
      check("ena_low_busy_held", 32'(bus.busy),     32'd1);
      check("ena_low_no_valid",  32'(bus.rd_valid), 32'd0);
    end
    check("ena_low_no_drop", 32'(bus.cmd_drop), 32'd0);
    bus.cmd_valid = 1'b0;
    bus.ena       = 1'b1;
    while (bus.busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ena_stall_busy_cycles", 32'(n), 32'd69);

    // Reset in the cycle that would clear word 10.
    for (int i = 0; i < 64; i++) issue(OP_WRITE, 2'd1, 6'(i), 8'(8'h80 + i));
    issue(OP_CLEAR, 2'd1, 6'd0, 8'h00);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mid_sweep_reset_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 64; i++) begin
      issue(OP_READ, 2'd1, 6'(i), 8'h00);
      check($sformatf("partial_b1_w%0d", i), 32'(bus.rd_data),
            (i < 10) ? 32'h00 : 32'(8'h80 + i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/banked_mem_ctrl.md
BANKED_MEM_CTRL -- requirements
Module: banked_mem_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, word width in bits.
REQ-002 Parameter ADDR_W, default 6, word address width; bank depth is 2^ADDR_W.
REQ-003 Parameter NUM_BANKS, default 4, bank count; power of two, >= 2; BANK_W = clog2(NUM_BANKS).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-006 ena  in  1  design enable; low freezes all state and ignores commands.
REQ-007 cmd_valid  in  1  command strobe, one command per cycle.
REQ-008 cmd_op  in  2  00 READ, 01 WRITE, 10 READ_NEXT (auto-increment), 11 CLEAR_BANK.
REQ-009 cmd_bank  in  BANK_W  target bank.
REQ-010 cmd_addr  in  ADDR_W  target word address (ignored for READ_NEXT and CLEAR_BANK).
REQ-011 wr_data  in  DATA_W  write data for WRITE.
REQ-012 rd_data  out  DATA_W  registered read data.
REQ-013 rd_valid  out  1  one-cycle pulse marking rd_data valid.
REQ-014 busy  out  1  high while a CLEAR_BANK sweep is in progress.
REQ-015 cmd_drop  out  1  sticky flag: a command was presented while busy.

Function
REQ-016 A command is accepted when ena=1, cmd_valid=1, busy=0.
REQ-017 WRITE stores wr_data at (cmd_bank, cmd_addr) on the accepting edge; no rd_valid.
REQ-018 READ returns the word at (cmd_bank, cmd_addr) on rd_data with rd_valid=1 exactly one cycle after acceptance (latency 1).
REQ-019 READ or WRITE loads the stream pointer with bank=cmd_bank, addr=cmd_addr+1 modulo 2^ADDR_W.
REQ-020 READ_NEXT reads at the stream pointer (latency 1, as REQ-018), then increments the pointer address modulo 2^ADDR_W; bank does not change on wrap.
REQ-021 Back-to-back READ/READ_NEXT commands produce back-to-back rd_valid pulses, one per command, in order.
REQ-022 A WRITE followed next cycle by a READ to the same address returns the newly written data.
REQ-023 FSM states IDLE, CLEAR; IDLE->CLEAR on accepted CLEAR_BANK; CLEAR writes zero to word 0..2^ADDR_W-1 of the target bank, one word per enabled cycle; CLEAR->IDLE after the last word is written.
REQ-024 busy is high from the cycle after CLEAR_BANK acceptance through the cycle writing the last word; sweep takes 2^ADDR_W enabled cycles.
REQ-025 Commands presented while busy=1 are discarded and set cmd_drop; cmd_drop clears only on reset.
REQ-026 With ena=0: no command accepted, cmd_drop not set, FSM and sweep counter hold, rd_data holds, rd_valid=0.
REQ-027 rd_data holds its last value when rd_valid=0.
REQ-028 CLEAR_BANK does not alter the stream pointer or other banks.

Reset
REQ-029 On rst_n=0 at a clock edge: FSM=IDLE, sweep counter=0, stream pointer=0/0, rd_data=0, rd_valid=0, busy=0, cmd_drop=0.
REQ-030 Memory contents are not reset; reset mid-sweep leaves words already cleared at zero, remaining words unchanged.
REQ-031 Commands presented in the reset cycle are ignored.

Structure
REQ-032 Shared package banked_mem_pkg holds the cmd_op encoding enum, FSM state typedef and default parameter constants.
REQ-033 One sub-module mem_bank (single-port synchronous DATA_W x 2^ADDR_W array, registered read) is instantiated NUM_BANKS times.

Verification
REQ-034 WRITE bank1 addr 0x05 data 0xA5, next cycle READ bank1 addr 0x05 -> rd_valid next cycle, rd_data=0xA5; bank0 addr 0x05 reads unaffected.
REQ-035 WRITE bank2 addr 62..63 = 0x11,0x22, write addr 0 = 0x33; READ addr 62 then READ_NEXT x2 -> 0x22, 0x33 (wrap to 0, bank stays 2).
REQ-036 Fill bank3 nonzero, CLEAR_BANK bank3 -> busy high 64 cycles, then all 64 words read 0x00; bank0 intact.
REQ-037 READ during busy -> no rd_valid, cmd_drop=1 and stays 1 until rst_n=0.
REQ-038 rst_n=0 at sweep word 10 -> busy=0 next cycle; words 0..9 read 0x00, words 10..63 keep prior values.
REQ-039 ena=0 for 5 cycles mid-sweep -> busy held, sweep completes 5 cycles later; commands during ena=0 neither execute nor set cmd_drop.
